// File: rtl/display_word_sequencer.sv
// Queues 32-bit hex words and shows each on an 8-digit seven-segment front end.
// Each word is held for HOLD_CYCLES. Leading zeros can optionally be blanked.
module display_word_sequencer #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int DEPTH       = 4,
  parameter int BLANK_LZ    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [31:0]              data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic [3:0]               dig7,
  output logic [3:0]               dig6,
  output logic [3:0]               dig5,
  output logic [3:0]               dig4,
  output logic [3:0]               dig3,
  output logic [3:0]               dig2,
  output logic [3:0]               dig1,
  output logic [3:0]               dig0,
  output logic [7:0]               turn_on,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [HW-1:0]   r_hold;
  logic [31:0]     r_disp;
  logic            w_push, w_pop, w_empty;
  logic [7:0]      w_lz;

  assign data_ready = (r_count != FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = data_valid & data_ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = SHOW;
      end
      SHOW: if (!w_empty && r_hold == HOLD_MAX) w_pop = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_pop       = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pointers are exactly AW bits wide, so the natural overflow gives the wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_hold <= '0;
    end else if (flush) begin
      r_disp <= '0;
      r_hold <= '0;
    end else if (w_pop) begin
      r_disp <= r_mem[r_rptr];
      r_hold <= '0;
    end else if (r_state == SHOW && r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HW'(1);
    end
  end

  // Digit i stays lit when it or any more-significant digit is nonzero.
  for (genvar i = 0; i < 8; i++) begin : g_lz
    assign w_lz[i] = |r_disp[31:4*i];
  end

  always_comb begin
    turn_on = 8'h00;
    if (r_state == SHOW) turn_on = (BLANK_LZ != 0) ? (w_lz | 8'h01) : 8'hFF;
  end

  assign {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0} = r_disp;
  assign fifo_count = r_count;
endmodule

// File: doc/display_word_sequencer.md
DISPLAY_WORD_SEQUENCER -- requirements
Module: display_word_sequencer

Interface
REQ-001: The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the number of cycles each word is displayed before the next may replace it (legal range >= 2).
REQ-002: The block SHALL have parameter DEPTH, default 4, giving the word FIFO depth (power of two, >= 2).
REQ-003: The block SHALL have parameter BLANK_LZ, default 1: 1 = leading-zero blanking on; 0 = all eight digits lit while showing.
REQ-004: The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005: The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006: The block SHALL have port flush, input, 1, a synchronous clear of the FIFO and the display.
REQ-007: The block SHALL have port data_in, input, 32, the word to display, with nibble [4i+3:4i] as digit i.
REQ-008: The block SHALL have port data_valid, input, 1; data_in is offered when high.
REQ-009: The block SHALL have port data_ready, output, 1; it is high when the FIFO can accept a word.
REQ-010: The block SHALL have ports dig7..dig0, output, 4 each; they carry the hex nibbles that feed the seven-segment controller inputs in7..in0.
REQ-011: The block SHALL have port turn_on, output, 8; it is the per-digit enable, where bit i lights digit i.
REQ-012: The block SHALL have port fifo_count, output, $clog2(DEPTH)+1, giving the number of words queued.

Function
REQ-013: The block SHALL accept a word on a rising edge where data_valid and data_ready are both high and flush is low; data_ready SHALL equal (fifo_count != DEPTH), registered-derived, with no combinational path from data_valid.
REQ-014: The FIFO SHALL be first-in first-out, and its read and write pointers SHALL wrap modulo DEPTH.
REQ-015: A push and a pop on the same edge SHALL leave fifo_count unchanged, and the popped word SHALL be the oldest word.
REQ-016: The block SHALL have two states, IDLE and SHOW, and SHALL be in IDLE after reset.
REQ-017: In IDLE, when fifo_count is nonzero on an edge, the block SHALL pop one word into the display register, clear the hold counter to 0 and enter SHOW.
REQ-018: In SHOW, the hold counter SHALL increment each cycle and saturate at HOLD_CYCLES-1.
REQ-019: In SHOW with hold counter == HOLD_CYCLES-1 and fifo_count nonzero, the block SHALL pop the next word, load it, and clear the counter to 0.
REQ-020: In SHOW with the FIFO empty, the block SHALL hold the last word indefinitely, and a word arriving later SHALL be loaded on the first edge where it is in the FIFO.
REQ-021: Latency from the accepting edge of a word (FIFO empty, IDLE or counter saturated) to its appearance on dig* SHALL be exactly one further edge.
REQ-022: dig7..dig0 SHALL be driven directly from the display register, with no combinational path from data_in.
REQ-023: In SHOW with BLANK_LZ=1, turn_on[i] SHALL be 1 iff i==0 or any digit j >= i is nonzero.
REQ-024: In SHOW with BLANK_LZ=0, turn_on SHALL be 8'hFF.
REQ-025: In IDLE, turn_on SHALL be 8'h00.
REQ-026: flush SHALL have priority over push and pop: on the edge, fifo_count becomes 0, pointers reset, the display register clears, and the state returns to IDLE.
REQ-027: A word offered on a flush edge SHALL be discarded.

Reset
REQ-028: Asserting rst_n low SHALL immediately, without a clock, force state=IDLE, fifo_count=0, pointers=0, hold counter=0, dig7..dig0=0, turn_on=8'h00 and data_ready=1.
REQ-029: Release of rst_n SHALL be applied synchronously to clk by the integrating top level, and the block SHALL accept a word on the first edge after release.
REQ-030: Reset asserted mid-operation SHALL discard all queued and displayed words.

Verification (HOLD_CYCLES=4, DEPTH=4, BLANK_LZ=1)
REQ-031: The bench SHALL cover this case: push 32'h0000_00A5 in IDLE -> next edge dig1=A, dig0=5, turn_on=8'h03, fifo_count=0.
REQ-032: The bench SHALL cover this case: push 32'h1234_5678, 32'h0000_0000, 32'h00F0_0000 back-to-back -> 12345678 is shown for 4 cycles, then 0 is shown with turn_on=8'h01 for 4 cycles, then turn_on=8'h3F.
REQ-033: The bench SHALL cover this case: while a word is displayed, push 5 words with data_valid held high -> data_ready drops when fifo_count=4, the 5th word is accepted only after a pop, and all words display in order.
REQ-034: The bench SHALL cover this case: with the FIFO empty and the counter saturated, push 32'hDEAD_BEEF -> it is displayed one edge later with turn_on=8'hFF.
REQ-035: The bench SHALL cover this case: assert flush with fifo_count=3 and data_valid high -> next edge fifo_count=0, turn_on=8'h00, state IDLE, and the offered word is lost.
REQ-036: The bench SHALL cover this case: drive rst_n low between clock edges mid-SHOW -> outputs are zero before the next edge, and data_ready=1.
